arc4_smem_arbiter: RTL

- Round-robin arbiter that shares the single-port 256x8 S memory between the ARC4 requesters: 0 = init, 1 = ksa, 2 = prga.
- Grants are locked: an owner keeps the memory until it drops req, so multi-access swap sequences (read i, read j, write i, write j) are atomic.
- Tracks the memory's 1-cycle read latency and routes read data back to the requester that issued the read.
- Sits between the phase FSMs and the S memory instance inside the task top level.

---
 rtl/arc4_smem_arbiter_if.sv | 16 +
 rtl/arc4_smem_arbiter.sv | 61 ++++++
 2 files changed

// File: rtl/arc4_smem_arbiter_if.sv
// arc4_smem_arbiter_if: requester-side bus between the ARC4 phase FSMs and the S memory arbiter.
interface arc4_smem_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] wr;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ*DW-1:0] wrdata;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] rdvalid;
    logic [DW-1:0] rddata;
    modport master(output req, wr, addr, wrdata, input gnt, rdvalid, rddata);
    modport slave(input req, wr, addr, wrdata, output gnt, rdvalid, rddata);
endinterface

// File: rtl/arc4_smem_arbiter.sv
// arc4_smem_arbiter: locked round-robin sharing of the single-port S memory with read-data return routing.
module arc4_smem_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic clk,
    input  logic rst,
    arc4_smem_arbiter_if.slave bus,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wrdata,
    output logic mem_wren,
    input  logic [DW-1:0] mem_q
);
    localparam int IW = $clog2(N_REQ);
    typedef enum logic {IDLE, OWNED} state_t;
    state_t state;
    logic [IW-1:0] owner, ptr, rd_tag, base, idx, nxt;
    logic [N_REQ-1:0] gnt;
    logic any, acc, rd_pending;
    // Search starts one past the current owner (or the last owner when idle), so the releasing owner comes last.
    always_comb begin
        base = (state == OWNED) ? owner : ptr;
        idx = '0;
        nxt = '0;
        any = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = IW'((int'(base) + i) % N_REQ);
            if (bus.req[idx]) begin
                nxt = idx;
                any = 1'b1;
            end
        end
    end
    assign acc = (state == OWNED) && bus.req[owner];
    assign mem_addr = acc ? bus.addr[int'(owner)*AW +: AW] : '0;
    assign mem_wrdata = acc ? bus.wrdata[int'(owner)*DW +: DW] : '0;
    assign mem_wren = acc & bus.wr[owner];
    assign bus.gnt = gnt;
    assign bus.rdvalid = rd_pending ? N_REQ'(1) << rd_tag : '0;
    assign bus.rddata = mem_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            ptr <= IW'(N_REQ - 1);
            gnt <= '0;
            rd_pending <= 1'b0;
            rd_tag <= '0;
        end else begin
            rd_pending <= acc & ~bus.wr[owner];
            rd_tag <= owner;
            if (state == IDLE || !bus.req[owner]) begin
                if (state == OWNED) ptr <= owner;
                state <= any ? OWNED : IDLE;
                owner <= any ? nxt : owner;
                gnt <= any ? N_REQ'(1) << nxt : '0;
            end
        end
    end
endmodule
